// File: rtl/fsm_step_driver.sv
// fsm_step_driver
// Initiator side of the start/step1/step2/step3 sequencing interface.
// Issues single-cycle start/step pulses to a stepped 4-state phase FSM,
// waits for each phase change on its 3-bit phase code, runs a programmed
// number of step1->step2->step3 loops with a dwell between steps, flags a
// timeout when the stepped FSM stalls and pulses done at the end.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   go, abort           run request (IDLE only) / cancel from any state
//   loops, dwell        loop count and inter-step dwell, latched with go
//   phase               phase code: 000 idle, 001 P1, 010 P2, 100 P3
//   start_o..step3_o    single-cycle request pulses
//   busy, done, err     status: not-IDLE, completion pulse, sticky error
//   loops_done          completed loops in current/last run
//
// Optional feature macro: FSM_STEP_DRIVER_PHASE_CHECK_EN
//   When defined, an unexpected phase code in WAIT or DWELL ends the run
//   with err immediately instead of waiting for the timeout.

module fsm_step_driver #(
    parameter int CNT_W   = 8,
    parameter int DWELL_W = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               abort,
    input  logic [CNT_W-1:0]   loops,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [2:0]         phase,
    output logic               start_o,
    output logic               step1_o,
    output logic               step2_o,
    output logic               step3_o,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   loops_done
);

    localparam int TIMER_W = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DWELL, S_DONE} state_t;
    typedef enum logic [1:0] {T_START, T_STEP1, T_STEP2, T_STEP3} target_t;

    // Phase code the stepped FSM should show once the target pulse lands.
    function automatic logic [2:0] expectedPhase(input target_t t);
        case (t)
            T_START: expectedPhase = 3'b001;
            T_STEP1: expectedPhase = 3'b010;
            T_STEP2: expectedPhase = 3'b100;
            default: expectedPhase = 3'b001;
        endcase
    endfunction

    // START is only ever issued once; after STEP3 the loop wraps to STEP1.
    function automatic target_t nextTarget(input target_t t);
        case (t)
            T_START: nextTarget = T_STEP1;
            T_STEP1: nextTarget = T_STEP2;
            T_STEP2: nextTarget = T_STEP3;
            default: nextTarget = T_STEP1;
        endcase
    endfunction

    // Pulse vector ordering is {step3, step2, step1, start}.
    function automatic logic [3:0] pulseFor(input target_t t);
        case (t)
            T_START: pulseFor = 4'b0001;
            T_STEP1: pulseFor = 4'b0010;
            T_STEP2: pulseFor = 4'b0100;
            default: pulseFor = 4'b1000;
        endcase
    endfunction

    state_t             r_state;
    target_t            r_target;
    logic [CNT_W-1:0]   r_loops;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [TIMER_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_loopsDone;
    logic               r_err;
    logic               r_busy;
    logic               r_done;
    logic [3:0]         r_pulse;
`ifdef FSM_STEP_DRIVER_PHASE_CHECK_EN
    logic [2:0]         r_lastPhase;
`endif

    logic [CNT_W-1:0]   w_loopsNext;
    logic               w_match;
    logic               w_finish;

    assign w_loopsNext = r_loopsDone + 1'b1;
    assign w_match     = (phase == expectedPhase(r_target));
    // Run ends after START when no loops were requested, or after the
    // STEP3 that completes the last loop.
    assign w_finish    = ((r_target == T_START) && (r_loops == '0)) ||
                         ((r_target == T_STEP3) && (w_loopsNext == r_loops));

    // Single sequencing FSM. Pulses, busy and done are all registered and set
    // on the edge that enters the state they belong to, so nothing on an
    // output depends combinationally on an input. abort takes priority over
    // everything; in IDLE it simply keeps go from being accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_target    <= T_START;
            r_loops     <= '0;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_loopsDone <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pulse     <= '0;
`ifdef FSM_STEP_DRIVER_PHASE_CHECK_EN
            r_lastPhase <= '0;
`endif
        end else begin
            r_pulse <= '0;
            r_done  <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (go) begin
                            r_loops     <= loops;
                            r_dwell     <= dwell;
                            r_loopsDone <= '0;
                            r_err       <= 1'b0;
                            r_busy      <= 1'b1;
`ifdef FSM_STEP_DRIVER_PHASE_CHECK_EN
                            r_lastPhase <= phase;
`endif
                            if (phase == 3'b000) begin
                                r_target <= T_START;
                                r_state  <= S_ISSUE;
                                r_pulse  <= pulseFor(T_START);
                            end else if (phase == 3'b001) begin
                                r_target <= T_STEP1;
                                if (loops == '0) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= S_ISSUE;
                                    r_pulse <= pulseFor(T_STEP1);
                                end
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                    end
                    S_WAIT: begin
                        r_timer <= r_timer + 1'b1;
                        if (w_match) begin
`ifdef FSM_STEP_DRIVER_PHASE_CHECK_EN
                            r_lastPhase <= phase;
`endif
                            if (r_target == T_STEP3) begin
                                r_loopsDone <= w_loopsNext;
                            end
                            if (w_finish) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_target <= nextTarget(r_target);
                                if (r_dwell == '0) begin
                                    r_state <= S_ISSUE;
                                    r_pulse <= pulseFor(nextTarget(r_target));
                                end else begin
                                    r_cnt   <= r_dwell;
                                    r_state <= S_DWELL;
                                end
                            end
                        end
`ifdef FSM_STEP_DRIVER_PHASE_CHECK_EN
                        else if (phase != r_lastPhase) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
`endif
                        else if (r_timer == TIMER_LAST) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    S_DWELL: begin
`ifdef FSM_STEP_DRIVER_PHASE_CHECK_EN
                        if (phase != r_lastPhase) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else
`endif
                        if (r_cnt == DWELL_W'(1)) begin
                            r_state <= S_ISSUE;
                            r_pulse <= pulseFor(r_target);
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign start_o    = r_pulse[0];
    assign step1_o    = r_pulse[1];
    assign step2_o    = r_pulse[2];
    assign step3_o    = r_pulse[3];
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign loops_done = r_loopsDone;

endmodule

// File: tb/tb_fsm_step_driver.sv
// tb_fsm_step_driver
// Scoreboard bench for fsm_step_driver. A stepped-FSM model drives phase.
// For each run the reference model computes, from the sequencing rules, the
// cycle of every pulse and of done plus the final err/loops_done; these are
// queued before go. A monitor pops and compares whenever a pulse or done
// appears, and also checks queued quiet-time status snapshots.

module tb_fsm_step_driver;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] loopsIn = '0;
    logic [7:0] dwellIn = '0;
    logic [2:0] tbPhase;
    logic       start_o, step1_o, step2_o, step3_o, busy, done, err;
    logic [7:0] loops_done;

    logic       loadPhase = 1'b0;
    logic [2:0] presetPhase = 3'b000;
    int         fsmMode = 0;   // 0 responsive, 1 ignores step2, 2 answers step1 with 011

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic       lastErr = 1'b0;
    logic [7:0] lastLd = '0;

    typedef struct { int kind; int cyc; logic err; logic [7:0] ld; } ev_t;
    typedef struct { int cyc; logic busy; logic err; logic [7:0] ld; string name; } st_t;
    ev_t evQ[$];
    st_t stQ[$];

    fsm_step_driver #(.CNT_W(8), .DWELL_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .loops(loopsIn), .dwell(dwellIn), .phase(tbPhase),
        .start_o(start_o), .step1_o(step1_o), .step2_o(step2_o), .step3_o(step3_o),
        .busy(busy), .done(done), .err(err), .loops_done(loops_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stepped FSM model: registers a pulse at the edge ending the ISSUE cycle.
    always @(posedge clk or posedge reset) begin
        if (reset)              tbPhase <= 3'b000;
        else if (loadPhase)     tbPhase <= presetPhase;
        else if (start_o)       tbPhase <= 3'b001;
        else if (step1_o)       tbPhase <= (fsmMode == 2) ? 3'b011 : 3'b010;
        else if (step2_o) begin
            if (fsmMode != 1)   tbPhase <= 3'b100;
        end
        else if (step3_o)       tbPhase <= 3'b001;
    end

    function automatic string kname(input int k);
        case (k)
            0: kname = "start";
            1: kname = "step1";
            2: kname = "step2";
            3: kname = "step3";
            default: kname = "done";
        endcase
    endfunction

    // Monitor: consumes expected events as the DUT presents them.
    ev_t        curEv;
    st_t        curSt;
    logic [4:0] seen;
    always @(negedge clk) begin
        if (reset) evQ.delete();
        while (evQ.size() > 0 && evQ[0].cyc < cyc) begin
            curEv = evQ.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL missing_%s: got nothing by cycle %0d, required at cycle %0d",
                     kname(curEv.kind), cyc, curEv.cyc);
        end
        seen = {done, step3_o, step2_o, step1_o, start_o};
        for (int k = 0; k < 5; k++) begin
            if (seen[k]) begin
                checks++;
                if (evQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_%s: got pulse at cycle %0d, required none",
                             kname(k), cyc);
                end else begin
                    curEv = evQ.pop_front();
                    if (curEv.kind != k || curEv.cyc != cyc) begin
                        failures++;
                        $display("[TB] FAIL event_order: got %s@%0d, required %s@%0d",
                                 kname(k), cyc, kname(curEv.kind), curEv.cyc);
                    end else if (k == 4 && (err !== curEv.err || loops_done !== curEv.ld)) begin
                        failures++;
                        $display("[TB] FAIL done_status: got err=%0b loops_done=%0d, required err=%0b loops_done=%0d",
                                 err, loops_done, curEv.err, curEv.ld);
                    end
                end
            end
        end
        while (stQ.size() > 0 && stQ[0].cyc <= cyc) begin
            curSt = stQ.pop_front();
            checks++;
            if (curSt.cyc != cyc || busy !== curSt.busy || err !== curSt.err ||
                loops_done !== curSt.ld || done !== 1'b0 || seen[3:0] !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL %s: got busy=%0b err=%0b loops_done=%0d done=%0b pulses=%b at cycle %0d, required busy=%0b err=%0b loops_done=%0d done=0 pulses=0000 at cycle %0d",
                         curSt.name, busy, err, loops_done, done, seen[3:0], cyc,
                         curSt.busy, curSt.err, curSt.ld, curSt.cyc);
            end
        end
    end

    task automatic pushEv(input int kind, input int c, input logic e, input logic [7:0] ld);
        ev_t x;
        x.kind = kind; x.cyc = c; x.err = e; x.ld = ld;
        evQ.push_back(x);
    endtask

    // Queue a quiet-time status snapshot for the monitor to compare.
    task automatic checkOutput(input int c, input logic b, input logic e,
                               input logic [7:0] ld, input string name);
        st_t x;
        x.cyc = c; x.busy = b; x.err = e; x.ld = ld; x.name = name;
        stQ.push_back(x);
    endtask

    // Reference model: go accepted so that the first pulse is in cycle a.
    // Each responsive step costs pulse + one WAIT + dwell cycles.
    task automatic modelRun(input int loops, input int dwell, input logic [2:0] ph0,
                            input int mode, input int a, output int doneCyc,
                            output logic expErr, output logic [7:0] expLd);
        int t;
        t = a; expErr = 1'b0; expLd = '0; doneCyc = a;
        if (ph0 != 3'b000 && ph0 != 3'b001) begin
            expErr = 1'b1;
            pushEv(4, a, 1'b1, '0);
            return;
        end
        if (ph0 == 3'b001 && loops == 0) begin
            pushEv(4, a, 1'b0, '0);
            return;
        end
        if (ph0 == 3'b000) begin
            pushEv(0, t, 1'b0, '0);
            if (loops == 0) begin
                doneCyc = t + 2;
                pushEv(4, doneCyc, 1'b0, '0);
                return;
            end
            t += 2 + dwell;
        end
        for (int l = 0; l < loops; l++) begin
            for (int s = 1; s <= 3; s++) begin
                pushEv(s, t, 1'b0, '0);
                if ((mode == 1 && s == 2) || (mode == 2 && s == 1)) begin
`ifdef FSM_STEP_DRIVER_PHASE_CHECK_EN
                    doneCyc = (mode == 2) ? t + 2 : t + 1 + TIMEOUT;
`else
                    doneCyc = t + 1 + TIMEOUT;
`endif
                    expErr = 1'b1;
                    expLd = 8'(l);
                    pushEv(4, doneCyc, 1'b1, expLd);
                    return;
                end
                if (l == loops - 1 && s == 3) begin
                    doneCyc = t + 2;
                    expLd = 8'(loops);
                    pushEv(4, doneCyc, 1'b0, expLd);
                    return;
                end
                t += 2 + dwell;
            end
        end
    endtask

    task automatic preparePhase(input logic [2:0] ph0, input int mode);
        @(negedge clk);
        presetPhase = ph0;
        fsmMode = mode;
        loadPhase = 1'b1;
        @(negedge clk);
        loadPhase = 1'b0;
    endtask

    task automatic applyStimulus(input int loops, input int dwell, input logic [2:0] ph0,
                                 input int mode, input string name);
        int a, doneCyc;
        logic expErr;
        logic [7:0] expLd;
        preparePhase(ph0, mode);
        a = cyc + 1;
        modelRun(loops, dwell, ph0, mode, a, doneCyc, expErr, expLd);
        go = 1'b1;
        loopsIn = 8'(loops);
        dwellIn = 8'(dwell);
        @(negedge clk);
        go = 1'b0;
        loopsIn = 8'($urandom);
        dwellIn = 8'($urandom);
        checkOutput(doneCyc + 1, 1'b0, expErr, expLd, name);
        while (cyc < doneCyc + 2) @(negedge clk);
        lastErr = expErr;
        lastLd = expLd;
    endtask

    // Watchdog: the bench cannot hang even if the clock or tasks misbehave.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a, lp, dw, ph, md;
        logic [2:0] phs;

        repeat (3) @(negedge clk);
        checkOutput(cyc + 1, 1'b0, 1'b0, '0, "reset_state");
        @(negedge clk);
        #2 reset = 1'b0;

        applyStimulus(2, 0, 3'b000, 0, "two_loops_no_dwell");
        applyStimulus(1, 3, 3'b001, 0, "skip_start_dwell3");
        applyStimulus(2, 1, 3'b000, 1, "timeout_on_step2");

        // go and abort together in IDLE: nothing starts, sticky err holds.
        @(negedge clk);
        checkOutput(cyc + 1, 1'b0, lastErr, lastLd, "go_abort_idle");
        checkOutput(cyc + 6, 1'b0, lastErr, lastLd, "go_abort_quiet");
        go = 1'b1; abort = 1'b1; loopsIn = 8'd1; dwellIn = 8'd0;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        repeat (7) @(negedge clk);

        // Abort during the second WAIT (after step1).
        preparePhase(3'b000, 0);
        a = cyc + 1;
        pushEv(0, a, 1'b0, '0);
        pushEv(1, a + 2, 1'b0, '0);
        go = 1'b1; loopsIn = 8'd2; dwellIn = 8'd0;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        checkOutput(a + 4, 1'b0, 1'b0, '0, "abort_busy_low");
        checkOutput(a + 10, 1'b0, 1'b0, '0, "abort_no_more_pulses");
        @(negedge clk);
        abort = 1'b0;
        while (cyc < a + 11) @(negedge clk);
        lastErr = 1'b0; lastLd = '0;

        applyStimulus(1, 0, 3'b000, 2, "illegal_phase_after_step1");
        applyStimulus(0, 2, 3'b001, 0, "zero_loops_skip_start");
        applyStimulus(0, 1, 3'b000, 0, "zero_loops_start_only");
        applyStimulus(1, 0, 3'b110, 0, "illegal_initial_phase");

        // Reset while in DWELL after the first loop completed.
        preparePhase(3'b000, 0);
        a = cyc + 1;
        pushEv(0, a, 1'b0, '0);
        pushEv(1, a + 6, 1'b0, '0);
        pushEv(2, a + 12, 1'b0, '0);
        pushEv(3, a + 18, 1'b0, '0);
        checkOutput(a + 20, 1'b1, 1'b0, 8'd1, "mid_dwell_loops_done");
        go = 1'b1; loopsIn = 8'd2; dwellIn = 8'd4;
        @(negedge clk);
        go = 1'b0;
        while (cyc < a + 21) @(negedge clk);
        #2 reset = 1'b1;
        checkOutput(a + 22, 1'b0, 1'b0, '0, "reset_mid_run");
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        checkOutput(a + 24, 1'b0, 1'b0, '0, "idle_after_reset");
        @(negedge clk);
        @(negedge clk);
        lastErr = 1'b0; lastLd = '0;

        for (int i = 0; i < 14; i++) begin
            lp = int'($urandom_range(0, 3));
            dw = int'($urandom_range(0, 3));
            ph = int'($urandom_range(0, 5));
            md = int'($urandom_range(0, 4));
            phs = (ph <= 2) ? 3'b000 : (ph <= 4) ? 3'b001 : 3'(3'b010 + 3'($urandom_range(0, 5)));
            if (md > 2) md = md - 2; else md = 0;
            applyStimulus(lp, dw, phs, md, $sformatf("random_%0d", i));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
